uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rr_arb.sv | 43 ++++
 rtl/uart_tx_sched.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state type, oversampling constant and parity helper for the UART transmit scheduler.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity bit: total count of ones including this bit is even.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin arbiter: searches from the index after ptr, wrapping at NUM_REQ-1,
// and returns a one-hot grant plus its binary index.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               valid
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // First pending requester after the last granted one wins.
  always_comb begin
    grant  = '0;
    index  = '0;
    valid  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s = {1'b0, ptr} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(NUM_REQ)) begin
        cand_s = IW'(sum_s - (IW+1)'(NUM_REQ));
      end else begin
        cand_s = sum_s[IW-1:0];
      end
      if (!valid && req[cand_s]) begin
        valid         = 1'b1;
        grant[cand_s] = 1'b1;
        index         = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: round-robin grant, 16x oversampled framing.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DBITS-1:0]   data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       done,
  output logic                       tx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  uart_state_e        state_r, state_nx_s;
  logic [SW-1:0]      s_r, s_nx_s;
  logic [NW-1:0]      n_r, n_nx_s;
  logic [DBITS-1:0]   shift_r, shift_nx_s;
  logic               tx_r, tx_nx_s;
  logic               busy_r, busy_nx_s;
  logic               done_r, done_nx_s;
  logic [NUM_REQ-1:0] ack_r, ack_nx_s;
  logic [IW-1:0]      owner_r, owner_nx_s;
  logic [IW-1:0]      ptr_r, ptr_nx_s;
`ifdef UART_TX_PARITY_EN
  logic               par_r, par_nx_s;
`endif

  logic [NUM_REQ-1:0] grant_s;
  logic [IW-1:0]      gidx_s;
  logic               gvalid_s;
  logic [DBITS-1:0]   gbyte_s;

  uart_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .grant (grant_s),
    .index (gidx_s),
    .valid (gvalid_s)
  );

  assign gbyte_s = DBITS'(data >> (int'(gidx_s) * DBITS));

  // Register bank; reset aborts any frame and gives requester 0 top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      s_r     <= '0;
      n_r     <= '0;
      shift_r <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ack_r   <= '0;
      owner_r <= '0;
      ptr_r   <= IW'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      s_r     <= s_nx_s;
      n_r     <= n_nx_s;
      shift_r <= shift_nx_s;
      tx_r    <= tx_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      ack_r   <= ack_nx_s;
      owner_r <= owner_nx_s;
      ptr_r   <= ptr_nx_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_nx_s;
`endif
    end
  end

  // Next-state and next-output logic; counters advance only on tick cycles.
  always_comb begin
    state_nx_s = state_r;
    s_nx_s     = s_r;
    n_nx_s     = n_r;
    shift_nx_s = shift_r;
    tx_nx_s    = tx_r;
    done_nx_s  = 1'b0;
    ack_nx_s   = '0;
    owner_nx_s = owner_r;
    ptr_nx_s   = ptr_r;
`ifdef UART_TX_PARITY_EN
    par_nx_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        tx_nx_s = 1'b1;
        s_nx_s  = '0;
        n_nx_s  = '0;
        if (gvalid_s) begin
          state_nx_s = START;
          ack_nx_s   = grant_s;
          owner_nx_s = gidx_s;
          ptr_nx_s   = gidx_s;
          shift_nx_s = gbyte_s;
          tx_nx_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_nx_s   = even_parity(64'(gbyte_s));
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        tx_nx_s = 1'b0;
        if (tick && (s_r == SW'(OVERSAMPLE - 1))) begin
          s_nx_s     = '0;
          n_nx_s     = '0;
          state_nx_s = DATA;
          tx_nx_s    = shift_r[0];
        end else if (tick) begin
          s_nx_s = s_r + SW'(1);
        end else begin
          s_nx_s = s_r;
        end
      end
      DATA: begin
        if (tick && (s_r == SW'(OVERSAMPLE - 1))) begin
          s_nx_s     = '0;
          shift_nx_s = shift_r >> 1;
          if (n_r == NW'(DBITS - 1)) begin
            n_nx_s = '0;
`ifdef UART_TX_PARITY_EN
            state_nx_s = PARITY;
            tx_nx_s    = par_r;
`else
            state_nx_s = STOP;
            tx_nx_s    = 1'b1;
`endif
          end else begin
            n_nx_s  = n_r + NW'(1);
            tx_nx_s = shift_nx_s[0];
          end
        end else if (tick) begin
          s_nx_s = s_r + SW'(1);
        end else begin
          s_nx_s = s_r;
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (tick && (s_r == SW'(OVERSAMPLE - 1))) begin
          s_nx_s     = '0;
          state_nx_s = STOP;
          tx_nx_s    = 1'b1;
        end else if (tick) begin
          s_nx_s = s_r + SW'(1);
        end else begin
          s_nx_s = s_r;
        end
`else
        state_nx_s = IDLE;
        tx_nx_s    = 1'b1;
        s_nx_s     = '0;
`endif
      end
      STOP: begin
        tx_nx_s = 1'b1;
        if (tick && (s_r == SW'(SB_TICK - 1))) begin
          s_nx_s     = '0;
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else if (tick) begin
          s_nx_s = s_r + SW'(1);
        end else begin
          s_nx_s = s_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        tx_nx_s    = 1'b1;
        s_nx_s     = '0;
        n_nx_s     = '0;
      end
    endcase
    busy_nx_s = (state_nx_s != IDLE);
  end

  assign ack   = ack_r;
  assign owner = owner_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign tx    = tx_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a round-robin model predicts each grant and byte,
// a monitor decodes the serial line tick by tick against the expected frame.
`timescale 1ns/1ps
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FT = NBITS * 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic [3:0]  req   = 4'b0;
  logic [31:0] data  = 32'h0;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        busy, done, tx;

  uart_tx_sched #(.NUM_REQ(4), .DBITS(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .data(data),
    .ack(ack), .owner(owner), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] b; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = 3;
  bit tick_en = 1'b1;
  int tick_ph = 0;
  bit active = 1'b0;
  int mon_k = 0;
  int ack_cnt = 0;
  int cur_idx = 0;
  logic [15:0] fb = 16'hFFFF;
  bit gap_pend = 1'b0;
  bit rst_chk  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last + i) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] frame_of(input logic [7:0] b);
    logic [15:0] f;
    f = 16'hFFFF;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Baud strobe: one clk in four unless frozen.
  initial begin
    forever begin
      @(posedge clk); #1;
      tick_ph = (tick_ph + 1) % 4;
      tick = tick_en && (tick_ph == 0);
    end
  end

  // Monitor: pops the expected frame at each ack and checks the line every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        active   = 1'b0;
        gap_pend = 1'b0;
        rst_chk  = 1'b1;
      end else begin
        if (rst_chk) begin
          check("reset_tx", 32'(tx), 32'd1);
          check("reset_busy", 32'(busy), 32'd0);
          check("reset_done", 32'(done), 32'd0);
          check("reset_ack", 32'(ack), 32'd0);
          check("reset_owner", 32'(owner), 32'd0);
          rst_chk = 1'b0;
        end
        if (gap_pend) begin
          check("one_clk_gap_ack", 32'(ack != 4'b0), 32'd1);
          gap_pend = 1'b0;
        end
        if (done) begin
          check("done_in_frame", 32'(active), 32'd1);
          check("done_ticks", 32'(mon_k), 32'(FT));
          check("done_owner", 32'(owner), 32'(cur_idx));
          check("idle_tx", 32'(tx), 32'd1);
          check("idle_busy", 32'(busy), 32'd0);
          active   = 1'b0;
          gap_pend = (req != 4'b0);
        end
        if (ack != 4'b0) begin
          check("ack_onehot", 32'($onehot(ack)), 32'd1);
          check("ack_while_idle", 32'(active), 32'd0);
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got %b expected none at %0t", ack, $time);
          end else begin
            mon_e = q.pop_front();
            check("ack_idx", 32'(ack), 32'd1 << mon_e.idx);
            check("owner", 32'(owner), 32'(mon_e.idx));
            fb      = frame_of(mon_e.b);
            cur_idx = mon_e.idx;
          end
          active = 1'b1;
          mon_k  = 0;
          ack_cnt++;
        end
        if (active) begin
          if (mon_k < FT) begin
            check("tx_bit", 32'(tx), 32'(fb[4'(mon_k / 16)]));
            check("busy_in_frame", 32'(busy), 32'd1);
            if (tick) mon_k++;
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL done_missing: got no done expected done after %0d ticks at %0t", FT, $time);
            active = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_ack(input int prev);
    int c;
    c = 0;
    while (ack_cnt == prev && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    check("ack_timeout", 32'(ack_cnt != prev), 32'd1);
  endtask

  task automatic issue(input logic [3:0] r, input logic [31:0] d, input bit keep);
    int idx;
    int prev;
    data = d;
    req  = r;
    idx  = rr_pick(r, model_last);
    q.push_back('{idx, 8'(d >> (idx * 8))});
    model_last = idx;
    prev = ack_cnt;
    wait_ack(prev);
    if (!keep) req = 4'b0;
  endtask

  task automatic wait_k(input int target);
    int c;
    c = 0;
    while (!(active && mon_k >= target) && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    check("wait_tick_timeout", 32'(active && mon_k >= target), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((q.size() != 0 || active) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain", 32'(q.size() == 0 && !active), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_last = 3;
    q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // single requester, known byte
    issue(4'b0001, 32'h0000_00A5, 1'b0);
    drain();
    do_reset(2);
    // all requesters pending: 0,1,2,3,0
    for (int i = 0; i < 5; i++) issue(4'b1111, $urandom(), i < 4);
    // grant to 1, then 0101 gives 2 then 0
    issue(4'b0010, $urandom(), 1'b1);
    issue(4'b0101, $urandom(), 1'b1);
    issue(4'b0101, $urandom(), 1'b0);
    // baud strobe frozen mid-data
    issue(4'b1000, $urandom(), 1'b0);
    wait_k(16 * 3 + 5);
    tick_en = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    tick_en = 1'b1;
    drain();
    // reset in the middle of a frame
    issue(4'b0100, $urandom(), 1'b0);
    wait_k(50);
    do_reset(1);
    issue(4'b1010, $urandom(), 1'b0);
    drain();
    issue(4'b0001, 32'hC3C3_C307, 1'b0);
    drain();
    // randomized traffic
    for (int i = 0; i < 20; i++) begin
      bit keep;
      keep = ($urandom_range(0, 1) == 1) && (i < 19);
      issue(4'($urandom_range(1, 15)), $urandom(), keep);
      if (!keep && $urandom_range(0, 3) == 0) drain();
    end
    drain();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
